// File: rtl/usb_out_reader_pkg.sv
// usb_out_reader_pkg
//   Shared constants and types for the OUT-endpoint reader.
//   ADDR_W  : OUT buffer address width
//   LEN_W   : width of the packet length reported by usb2_top
//   MAX_PKT : largest packet the OUT buffer can hold, in bytes
//   state_t : reader state encoding
//   clamp_len() : limits a reported length to MAX_PKT
package usb_out_reader_pkg;

  localparam int ADDR_W  = 9;
  localparam int LEN_W   = 10;
  localparam int MAX_PKT = 512;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_ARM     = 3'd4,
    ST_ACK_HI  = 3'd5,
    ST_ACK_LO  = 3'd6
  } state_t;

  // A length above the buffer size can only come from a misbehaving host;
  // reading past MAX_PKT would wrap the address and replay old bytes.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_PKT)) ? LEN_W'(MAX_PKT) : len;
  endfunction

endpackage

// File: rtl/usb_out_reader_sync_2ff.sv
// sync_2ff
//   Two-flop single-bit synchroniser into the clk domain.
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears both flops
//   d     : asynchronous input bit
//   q     : synchronised output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_out_reader.sv
// usb_out_reader
//   Drains OUT-endpoint packets from the usb2_top OUT buffer and presents
//   them as a valid/ready byte stream with first/last flags, then re-arms
//   the endpoint with a four-phase arm/ack handshake.
//   clk_50, reset        : system clock, async active-high reset
//   buf_out_hasdata/len  : packet present flag (ulpi domain) and length
//   buf_out_addr/q       : read port of the OUT buffer (READ_LAT latency)
//   buf_out_arm/arm_ack  : endpoint re-arm request and its acknowledge
//   usb_configured       : no new packet is started while low
//   rx_data/valid/ready  : byte stream, accepted when valid & ready
//   rx_first/rx_last     : qualify first and last byte of a packet
//   rx_zlp               : one-cycle pulse when an empty packet is drained
//   pkt_count            : packets drained, wraps at 16 bits
module usb_out_reader
  import usb_out_reader_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              buf_out_hasdata,
  input  logic [LEN_W-1:0]  buf_out_len,
  output logic [ADDR_W-1:0] buf_out_addr,
  input  logic [7:0]        buf_out_q,
  output logic              buf_out_arm,
  input  logic              buf_out_arm_ack,
  input  logic              usb_configured,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_first,
  output logic              rx_last,
  output logic              rx_zlp,
  output logic [15:0]       pkt_count
);

  localparam int CNT_W = 2;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   lat_cnt, lat_cnt_nxt;
  logic [LEN_W-1:0]   rem, rem_nxt;
  logic [LEN_W-1:0]   idx, idx_nxt, idx_inc;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [7:0]         data_nxt;
  logic [15:0]        count_nxt;
  logic               hasdata_s;
  logic               arm_ack_s;
  logic               is_last;

  sync_2ff u_sync_hasdata (
    .clk   (clk_50),
    .reset (reset),
    .d     (buf_out_hasdata),
    .q     (hasdata_s)
  );

  sync_2ff u_sync_arm_ack (
    .clk   (clk_50),
    .reset (reset),
    .d     (buf_out_arm_ack),
    .q     (arm_ack_s)
  );

  assign idx_inc = idx + LEN_W'(1);
  assign is_last = (idx == rem - LEN_W'(1));

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      lat_cnt      <= '0;
      rem          <= '0;
      idx          <= '0;
      buf_out_addr <= '0;
      rx_data      <= '0;
      pkt_count    <= '0;
    end else begin
      state        <= state_nxt;
      lat_cnt      <= lat_cnt_nxt;
      rem          <= rem_nxt;
      idx          <= idx_nxt;
      buf_out_addr <= addr_nxt;
      rx_data      <= data_nxt;
      pkt_count    <= count_nxt;
    end
  end

  // Stream outputs and the arm request decode from the state, so an
  // asynchronous reset drops them at once and aborts any packet in flight.
  // WAIT lasts READ_LAT+1 cycles: the address register settles on the first
  // edge and the RAM needs READ_LAT further edges before q reflects it.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    rem_nxt     = rem;
    idx_nxt     = idx;
    addr_nxt    = buf_out_addr;
    data_nxt    = rx_data;
    count_nxt   = pkt_count;
    rx_valid    = 1'b0;
    rx_first    = 1'b0;
    rx_last     = 1'b0;
    rx_zlp      = 1'b0;
    buf_out_arm = 1'b0;

    case (state)
      ST_IDLE: begin
        if (usb_configured && hasdata_s) begin
          state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        rem_nxt  = clamp_len(buf_out_len);
        idx_nxt  = '0;
        addr_nxt = '0;
        if (buf_out_len == '0) begin
          rx_zlp    = 1'b1;
          state_nxt = ST_ARM;
        end else begin
          lat_cnt_nxt = CNT_W'(READ_LAT);
          state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == '0) begin
          data_nxt  = buf_out_q;
          state_nxt = ST_PRESENT;
        end else begin
          lat_cnt_nxt = lat_cnt - CNT_W'(1);
        end
      end
      ST_PRESENT: begin
        rx_valid = 1'b1;
        rx_first = (idx == '0);
        rx_last  = is_last;
        if (rx_ready) begin
          if (is_last) begin
            state_nxt = ST_ARM;
          end else begin
            idx_nxt     = idx_inc;
            addr_nxt    = idx_inc[ADDR_W-1:0];
            lat_cnt_nxt = CNT_W'(READ_LAT);
            state_nxt   = ST_WAIT;
          end
        end
      end
      ST_ARM: begin
        buf_out_arm = 1'b1;
        count_nxt   = pkt_count + 16'd1;
        state_nxt   = ST_ACK_HI;
      end
      ST_ACK_HI: begin
        buf_out_arm = 1'b1;
        if (arm_ack_s) begin
          state_nxt = ST_ACK_LO;
        end
      end
      ST_ACK_LO: begin
        if (!arm_ack_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_out_reader.sv
// tb_usb_out_reader
//   Directed bench for usb_out_reader. Models the OUT buffer RAM with a
//   two-stage read pipeline and the usb2_top side of the arm handshake.
//   Expected bytes are queued when a packet is launched; a monitor pops and
//   compares them whenever the DUT completes a valid/ready transfer.
module tb_usb_out_reader;
  import usb_out_reader_pkg::*;

  logic              clk_50;
  logic              reset;
  logic              buf_out_hasdata;
  logic [LEN_W-1:0]  buf_out_len;
  logic [ADDR_W-1:0] buf_out_addr;
  logic [7:0]        buf_out_q;
  logic              buf_out_arm;
  logic              buf_out_arm_ack;
  logic              usb_configured;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_first;
  logic              rx_last;
  logic              rx_zlp;
  logic [15:0]       pkt_count;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         accepted = 0;
  int         valid_cycles = 0;
  int         zlp_cycles = 0;
  int         arm_rises = 0;
  int         max_addr = 0;
  int         ready_mode = 0;
  logic [7:0] mem [0:MAX_PKT-1];
  logic [7:0] ram_p1;

  usb_out_reader #(.READ_LAT(2)) dut (
    .clk_50          (clk_50),
    .reset           (reset),
    .buf_out_hasdata (buf_out_hasdata),
    .buf_out_len     (buf_out_len),
    .buf_out_addr    (buf_out_addr),
    .buf_out_q       (buf_out_q),
    .buf_out_arm     (buf_out_arm),
    .buf_out_arm_ack (buf_out_arm_ack),
    .usb_configured  (usb_configured),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_first        (rx_first),
    .rx_last         (rx_last),
    .rx_zlp          (rx_zlp),
    .pkt_count       (pkt_count)
  );

  initial begin
    clk_50 = 1'b0;
    forever #5 clk_50 = ~clk_50;
  end

  // OUT buffer: registered address stage plus registered output.
  always @(posedge clk_50) begin
    ram_p1    <= mem[buf_out_addr];
    buf_out_q <= ram_p1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Downstream ready: always high, or the repeating pattern 1,0,0,1.
  initial begin
    int phase = 0;
    rx_ready = 1'b1;
    forever begin
      @(posedge clk_50);
      #1;
      if (ready_mode == 0) begin
        rx_ready = 1'b1;
      end else begin
        rx_ready = (phase == 0) || (phase == 3);
        phase    = (phase + 1) % 4;
      end
    end
  end

  // Monitor: scoreboard pops, stall stability and event counters.
  initial begin
    logic       prev_stall = 1'b0;
    logic       arm_prev   = 1'b0;
    logic [7:0] held_data  = '0;
    logic       held_first = 1'b0;
    logic       held_last  = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk_50);
      if (reset) begin
        prev_stall = 1'b0;
        arm_prev   = 1'b0;
      end else begin
        if (rx_zlp) zlp_cycles++;
        if (rx_valid) valid_cycles++;
        if (rx_zlp && rx_valid) check_output("zlp_valid_overlap", 32'd1, 32'd0);
        if (buf_out_arm && !arm_prev) arm_rises++;
        arm_prev = buf_out_arm;
        if (int'(buf_out_addr) > max_addr) max_addr = int'(buf_out_addr);
        if (prev_stall) begin
          check_output("stall_hold", {21'd0, rx_valid, rx_first, rx_last, rx_data},
                       {21'd0, 1'b1, held_first, held_last, held_data});
        end
        if (rx_valid && rx_ready) begin
          if (sb.size() == 0) begin
            check_output("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check_output("byte", {22'd0, rx_first, rx_last, rx_data},
                         {22'd0, e.first, e.last, e.data});
          end
          accepted++;
        end
        prev_stall = rx_valid && !rx_ready;
        held_data  = rx_data;
        held_first = rx_first;
        held_last  = rx_last;
      end
    end
  end

  task automatic load_small();
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    mem[2] = 8'hFF;
    mem[3] = 8'h00;
  endtask

  task automatic push_bytes(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data  = mem[i];
      e.first = (i == 0);
      e.last  = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input int len);
    buf_out_len     = LEN_W'(len);
    buf_out_hasdata = 1'b1;
  endtask

  // usb2_top side: drop hasdata once arm is requested, then ack.
  task automatic finish_packet(input int ack_hold);
    int n = 0;
    while (!buf_out_arm && n < 5000) begin
      @(negedge clk_50);
      n++;
    end
    if (!buf_out_arm) check_output("arm_timeout", 32'd0, 32'd1);
    buf_out_hasdata = 1'b0;
    repeat (2) @(negedge clk_50);
    buf_out_arm_ack = 1'b1;
    repeat (ack_hold) @(negedge clk_50);
    n = 0;
    while (buf_out_arm && n < 50) begin
      @(negedge clk_50);
      n++;
    end
    check_output("arm_release", {31'd0, buf_out_arm}, 32'd0);
    buf_out_arm_ack = 1'b0;
    repeat (6) @(negedge clk_50);
  endtask

  initial begin
    int base_arm;
    int base_acc;
    int base_valid;
    int base_zlp;
    int n;

    reset           = 1'b1;
    buf_out_hasdata = 1'b0;
    buf_out_len     = '0;
    buf_out_arm_ack = 1'b0;
    usb_configured  = 1'b1;
    for (int i = 0; i < MAX_PKT; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk_50);

    check_output("reset_addr", 32'(buf_out_addr), 32'd0);
    check_output("reset_arm", {31'd0, buf_out_arm}, 32'd0);
    check_output("reset_stream", {21'd0, rx_valid, rx_first, rx_last, rx_data}, 32'd0);
    check_output("reset_zlp", {31'd0, rx_zlp}, 32'd0);
    check_output("reset_pkt_count", 32'(pkt_count), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_50);

    $display("[TB] four-byte packet, ready held high");
    load_small();
    base_arm = arm_rises;
    push_bytes(4);
    apply_stimulus(4);
    finish_packet(4);
    check_output("p1_drained", 32'(sb.size()), 32'd0);
    check_output("p1_arm_count", 32'(arm_rises - base_arm), 32'd1);
    check_output("p1_pkt_count", 32'(pkt_count), 32'd1);

    $display("[TB] four-byte packet, ready toggling");
    ready_mode = 1;
    base_acc   = accepted;
    push_bytes(4);
    apply_stimulus(4);
    finish_packet(4);
    ready_mode = 0;
    check_output("p2_drained", 32'(sb.size()), 32'd0);
    check_output("p2_bytes", 32'(accepted - base_acc), 32'd4);
    check_output("p2_pkt_count", 32'(pkt_count), 32'd2);

    $display("[TB] zero-length packet");
    base_valid = valid_cycles;
    base_zlp   = zlp_cycles;
    base_arm   = arm_rises;
    apply_stimulus(0);
    finish_packet(4);
    check_output("zlp_no_valid", 32'(valid_cycles - base_valid), 32'd0);
    check_output("zlp_pulse_len", 32'(zlp_cycles - base_zlp), 32'd1);
    check_output("zlp_arm_count", 32'(arm_rises - base_arm), 32'd1);
    check_output("zlp_pkt_count", 32'(pkt_count), 32'd3);

    $display("[TB] length 700 clamped to 512");
    for (int i = 0; i < MAX_PKT; i++) mem[i] = 8'(i);
    base_acc = accepted;
    base_arm = arm_rises;
    push_bytes(MAX_PKT);
    apply_stimulus(700);
    finish_packet(4);
    check_output("clamp_drained", 32'(sb.size()), 32'd0);
    check_output("clamp_bytes", 32'(accepted - base_acc), 32'd512);
    check_output("clamp_max_addr", 32'(max_addr), 32'd511);
    check_output("clamp_arm_count", 32'(arm_rises - base_arm), 32'd1);
    check_output("clamp_pkt_count", 32'(pkt_count), 32'd4);

    $display("[TB] reset during byte two");
    load_small();
    base_acc = accepted;
    push_bytes(4);
    apply_stimulus(4);
    n = 0;
    while ((accepted - base_acc) < 1 && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    check_output("rst_first_byte", 32'(accepted - base_acc), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_output("rst_stream", {21'd0, rx_valid, rx_first, rx_last, rx_data}, 32'd0);
    check_output("rst_addr", 32'(buf_out_addr), 32'd0);
    check_output("rst_arm", {31'd0, buf_out_arm}, 32'd0);
    check_output("rst_pkt_count", 32'(pkt_count), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk_50);
    base_arm = arm_rises;
    reset    = 1'b0;
    push_bytes(4);
    finish_packet(4);
    check_output("rst_reread", 32'(sb.size()), 32'd0);
    check_output("rst_arm_count", 32'(arm_rises - base_arm), 32'd1);
    check_output("rst_pkt_count_after", 32'(pkt_count), 32'd1);

    $display("[TB] usb_configured gate and long ack");
    usb_configured = 1'b0;
    base_valid     = valid_cycles;
    base_arm       = arm_rises;
    apply_stimulus(4);
    repeat (20) @(negedge clk_50);
    check_output("gate_no_valid", 32'(valid_cycles - base_valid), 32'd0);
    check_output("gate_no_arm", 32'(arm_rises - base_arm), 32'd0);
    check_output("gate_idle", 32'(dut.state), 32'(ST_IDLE));
    usb_configured = 1'b1;
    push_bytes(4);
    n = 0;
    while (!buf_out_arm && n < 500) begin
      @(negedge clk_50);
      n++;
    end
    check_output("gate_arm", {31'd0, buf_out_arm}, 32'd1);
    buf_out_hasdata = 1'b0;
    repeat (2) @(negedge clk_50);
    buf_out_arm_ack = 1'b1;
    repeat (5) @(negedge clk_50);
    check_output("ack_arm_dropped", {31'd0, buf_out_arm}, 32'd0);
    check_output("ack_hold_state", 32'(dut.state), 32'(ST_ACK_LO));
    buf_out_arm_ack = 1'b0;
    @(negedge clk_50);
    check_output("ack_still_waiting", 32'(dut.state), 32'(ST_ACK_LO));
    repeat (4) @(negedge clk_50);
    check_output("ack_back_idle", 32'(dut.state), 32'(ST_IDLE));
    check_output("gate_drained", 32'(sb.size()), 32'd0);
    check_output("gate_pkt_count", 32'(pkt_count), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
